// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the capture FIFO flow controller and its trigger logic.
// Holds the state encoding and the default FIFO geometry and watermarks.
package fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StDrain = 2'd2,
    StFlush = 2'd3
  } state_e;

  localparam int unsigned FifoCountW = 21;
  localparam int unsigned FifoDepth  = 12800;
  localparam int unsigned FifoHighWm = 12799;
  localparam int unsigned FifoLowWm  = 2560;
  localparam int unsigned FifoDropW  = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Holds at all-ones once reached; only a clear brings it back to zero.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_clr_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fifo_flow_ctrl.sv
// Fill/drain sequencer for the capture FIFO with watermark hysteresis, forced flush
// and a saturating count of refused producer writes.
module fifo_flow_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned COUNT_W = FifoCountW,
  parameter int unsigned DEPTH   = FifoDepth,
  parameter int unsigned HIGH_WM = FifoHighWm,
  parameter int unsigned LOW_WM  = FifoLowWm,
  parameter int unsigned DROP_W  = FifoDropW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable_i,
  input  logic               flush_i,
  input  logic               wr_req_i,
  input  logic               rd_req_i,
  input  logic [COUNT_W-1:0] fifo_rd_data_count_i,
  output logic               fifo_wr_en_o,
  output logic               fifo_rd_en_o,
  output logic [1:0]         state_o,
  output logic               fill_done_o,
  output logic               drain_done_o,
  output logic [DROP_W-1:0]  drop_cnt_o
);

  if (!((LOW_WM < HIGH_WM) && (HIGH_WM <= DEPTH))) begin : g_bad_wm
    $fatal(1, "fifo_flow_ctrl: watermarks must satisfy LOW_WM < HIGH_WM <= DEPTH");
  end

  localparam logic [COUNT_W-1:0] HighWmC = COUNT_W'(HIGH_WM);
  localparam logic [COUNT_W-1:0] LowWmC  = COUNT_W'(LOW_WM);

  state_e r_state, w_state_d;
  logic   r_fill_done, r_drain_done;
  logic   w_fill_done_d, w_drain_done_d;
  logic   w_at_high, w_at_low, w_empty;
  logic   w_drop_inc;

  assign w_at_high = (fifo_rd_data_count_i >= HighWmC);
  assign w_at_low  = (fifo_rd_data_count_i <= LowWmC);
  assign w_empty   = (fifo_rd_data_count_i == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_fill_done  <= 1'b0;
      r_drain_done <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_fill_done  <= w_fill_done_d;
      r_drain_done <= w_drain_done_d;
    end
  end

  // Priority: flush, then disable, then watermark. FLUSH only leaves on empty.
  always_comb begin
    w_state_d      = r_state;
    w_fill_done_d  = 1'b0;
    w_drain_done_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (flush_i)       w_state_d = StFlush;
        else if (enable_i) w_state_d = StFill;
      end
      StFill: begin
        if (flush_i)        w_state_d = StFlush;
        else if (!enable_i) w_state_d = StIdle;
        else if (w_at_high) begin
          w_state_d     = StDrain;
          w_fill_done_d = 1'b1;
        end
      end
      StDrain: begin
        if (flush_i)        w_state_d = StFlush;
        else if (!enable_i) w_state_d = StIdle;
        else if (w_at_low) begin
          w_state_d      = StFill;
          w_drain_done_d = 1'b1;
        end
      end
      StFlush: begin
        if (w_empty) begin
          w_state_d      = StIdle;
          w_drain_done_d = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    fifo_wr_en_o = 1'b0;
    fifo_rd_en_o = 1'b0;
    unique case (r_state)
      StIdle:  ;
      StFill:  fifo_wr_en_o = wr_req_i && !w_at_high;
      StDrain: fifo_rd_en_o = rd_req_i && !w_empty;
      StFlush: fifo_rd_en_o = !w_empty;
      default: ;
    endcase
  end

  assign w_drop_inc   = (r_state != StIdle) && wr_req_i && !fifo_wr_en_o;
  assign state_o      = r_state;
  assign fill_done_o  = r_fill_done;
  assign drain_done_o = r_drain_done;

  sat_counter #(
    .WIDTH(DROP_W)
  ) u_drop_cnt (
    .i_clk   (clk),
    .i_clr_n (reset),
    .i_inc   (w_drop_inc),
    .o_count (drop_cnt_o)
  );

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Scoreboard bench for fifo_flow_ctrl: directed vectors push expected outputs,
// a monitor pops and compares them once per cycle away from the clock edge.
module tb_fifo_flow_ctrl;

  localparam int unsigned CW = 21;
  localparam int unsigned DW = 4;

  typedef struct {
    int          id;
    logic        wr;
    logic        rd;
    logic [1:0]  st;
    logic        fd;
    logic        dd;
    logic [DW-1:0] drop;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable_i, flush_i, wr_req_i, rd_req_i;
  logic [CW-1:0] cnt;
  logic          wr_en, rd_en, fill_done, drain_done;
  logic [1:0]    state;
  logic [DW-1:0] drop_cnt;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   step_id = 0;
  bit   stim_done = 1'b0;

  always #5 clk = ~clk;

  fifo_flow_ctrl #(
    .COUNT_W (CW),
    .DROP_W  (DW)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .enable_i             (enable_i),
    .flush_i              (flush_i),
    .wr_req_i             (wr_req_i),
    .rd_req_i             (rd_req_i),
    .fifo_rd_data_count_i (cnt),
    .fifo_wr_en_o         (wr_en),
    .fifo_rd_en_o         (rd_en),
    .state_o              (state),
    .fill_done_o          (fill_done),
    .drain_done_o         (drain_done),
    .drop_cnt_o           (drop_cnt)
  );

  task automatic chk(input string name, input int id, input logic [31:0] got,
                     input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL step%0d %s: got %0d want %0d", id, name, got, want);
  endtask

  task automatic step(input logic rst, input logic en, input logic fl, input logic wr,
                      input logic rd, input int c, input logic ewr, input logic erd,
                      input int est, input logic efd, input logic edd, input int edrop);
    exp_t e;
    @(negedge clk);
    #1;
    reset = rst; enable_i = en; flush_i = fl; wr_req_i = wr; rd_req_i = rd;
    cnt = CW'(c);
    step_id++;
    e.id = step_id; e.wr = ewr; e.rd = erd; e.st = 2'(est);
    e.fd = efd; e.dd = edd; e.drop = DW'(edrop);
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("wr_en",      e.id, 32'(wr_en),      32'(e.wr));
        chk("rd_en",      e.id, 32'(rd_en),      32'(e.rd));
        chk("state",      e.id, 32'(state),      32'(e.st));
        chk("fill_done",  e.id, 32'(fill_done),  32'(e.fd));
        chk("drain_done", e.id, 32'(drain_done), 32'(e.dd));
        chk("drop_cnt",   e.id, 32'(drop_cnt),   32'(e.drop));
      end
    end
  end

  initial begin : driver
    reset = 1'b0; enable_i = 1'($urandom); flush_i = 1'($urandom);
    wr_req_i = 1'($urandom); rd_req_i = 1'($urandom); cnt = CW'($urandom_range(0, 20000));
    // rst en fl wr rd cnt | wr rd st fd dd drop
    step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
         int'($urandom_range(0, 20000)),             0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0,                           0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0,                           0, 0, 0, 0, 0, 0);
    // fill to high watermark
    step(1, 1, 0, 1, 0, 12798,                       0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 12798,                       1, 0, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0, 12799,                       0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0, 12799,                       0, 0, 2, 1, 0, 1);
    // drain to low watermark
    step(1, 1, 0, 0, 1, 2561,                        0, 1, 2, 0, 0, 2);
    step(1, 1, 0, 0, 1, 2560,                        0, 1, 2, 0, 0, 2);
    step(1, 1, 0, 0, 1, 2560,                        0, 0, 1, 0, 1, 2);
    // flush from FILL
    step(1, 1, 0, 1, 0, 5000,                        1, 0, 1, 0, 0, 2);
    step(1, 1, 1, 0, 0, 5000,                        0, 0, 1, 0, 0, 2);
    step(1, 1, 0, 0, 0, 5000,                        0, 1, 3, 0, 0, 2);
    step(1, 0, 1, 1, 0, 1,                           0, 1, 3, 0, 0, 2);
    step(1, 0, 0, 0, 0, 0,                           0, 0, 3, 0, 0, 3);
    step(1, 0, 0, 0, 0, 0,                           0, 0, 0, 0, 1, 3);
    // flush wins over high watermark
    step(1, 1, 0, 0, 0, 100,                         0, 0, 0, 0, 0, 3);
    step(1, 1, 1, 0, 0, 12799,                       0, 0, 1, 0, 0, 3);
    step(1, 1, 0, 0, 0, 12799,                       0, 1, 3, 0, 0, 3);
    step(1, 1, 0, 0, 0, 0,                           0, 0, 3, 0, 0, 3);
    // enter FILL already at high, then DRAIN already at low
    step(1, 1, 0, 0, 0, 12799,                       0, 0, 0, 0, 1, 3);
    step(1, 1, 0, 0, 0, 12799,                       0, 0, 1, 0, 0, 3);
    step(1, 1, 0, 0, 1, 2560,                        0, 1, 2, 1, 0, 3);
    // disable wins over low watermark
    step(1, 1, 0, 0, 0, 12800,                       0, 0, 1, 0, 1, 3);
    step(1, 0, 0, 0, 0, 2560,                        0, 0, 2, 1, 0, 3);
    step(1, 0, 0, 0, 0, 2560,                        0, 0, 0, 0, 0, 3);
    // drop counter saturation
    step(1, 1, 0, 1, 0, 12799,                       0, 0, 0, 0, 0, 3);
    for (int k = 0; k < 20; k++) begin
      step(1, 1, 0, 1, 0, 12799, 0, 0, (k == 0) ? 1 : 2, (k == 1) ? 1'b1 : 1'b0, 0,
           (3 + k > 15) ? 15 : 3 + k);
    end
    step(1, 1, 0, 1, 0, 12799,                       0, 0, 2, 0, 0, 15);
    // reset mid-operation
    step(0, 1, 0, 1, 0, 12799,                       0, 0, 2, 0, 0, 15);
    step(1, 0, 0, 0, 0, 0,                           0, 0, 0, 0, 0, 0);
    stim_done = 1'b1;
  end

  initial begin : finisher
    int budget;
    budget = 0;
    wait (stim_done);
    while (sb.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    repeat (2) @(negedge clk);
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain_scoreboard: got %0d pending want 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
